// File: rtl/shuffler_param.sv
// Parametrised in-place RAM shuffler: stride walk or LFSR-driven Fisher-Yates.
// Talks to a single-port synchronous RAM whose read data arrives one cycle after
// the address. Each swap takes six cycles: read i, read j, capture j, write j,
// write i, then advance the indices.
module shuffler_param #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned DEPTH  = 52,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned STRIDE = 3,
   parameter int unsigned OFFSET = 36,
   parameter int unsigned PASSES = 1,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic              clock,
   input  logic              resetN,
   input  logic              start,
   input  logic              mode,
   input  logic [15:0]       seed,
   input  logic              seedLoad,
   input  logic [DATA_W-1:0] memData,
   output logic [ADDR_W-1:0] nextA,
   output logic [DATA_W-1:0] newData,
   output logic              wren,
   output logic              busy,
   output logic              finish
);

   localparam int unsigned PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

   localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] OffsetIdx = ADDR_W'(OFFSET);
   localparam logic [ADDR_W-1:0] OneIdx    = ADDR_W'(1);
   localparam logic [ADDR_W:0]   StrideExt = (ADDR_W + 1)'(STRIDE);
   localparam logic [ADDR_W:0]   DepthExt  = (ADDR_W + 1)'(DEPTH);
   localparam logic [PASS_W-1:0] LastPass  = PASS_W'(PASSES - 1);
   localparam logic [PASS_W-1:0] OnePass   = PASS_W'(1);
   localparam logic [15:0]       LfsrMask  = 16'hB400;

   typedef enum logic [3:0] {
      StIdle,
      StDraw,
      StRdI,
      StRdJ,
      StCapJ,
      StWrJ,
      StWrI,
      StNext,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   i_q, i_d;
   logic [ADDR_W-1:0]   j_q, j_d;
   logic [PASS_W-1:0]   pass_q, pass_d;
   logic                mode_q, mode_d;
   logic [DATA_W-1:0]   reg_i_q, reg_i_d;
   logic [DATA_W-1:0]   reg_j_q, reg_j_d;
   logic [15:0]         lfsr_q, lfsr_d;

   logic [ADDR_W-1:0]   draw_mask;
   logic [ADDR_W-1:0]   cand;
   logic [ADDR_W:0]     j_sum;
   logic [ADDR_W-1:0]   j_wrap;
   logic                pass_end;

   // Smallest all-ones mask covering i: OR-smear every bit below the MSB.
   always_comb begin
      draw_mask = i_q;
      for (int k = 1; k < ADDR_W; k++) begin
         draw_mask = draw_mask | (i_q >> k);
      end
   end

   assign cand  = lfsr_q[ADDR_W-1:0] & draw_mask;
   // One extra bit so the wrap test cannot overflow when DEPTH == 2^ADDR_W.
   assign j_sum = {1'b0, j_q} + StrideExt;
   assign j_wrap = (j_sum >= DepthExt) ? ADDR_W'(j_sum - DepthExt) : j_sum[ADDR_W-1:0];
   assign pass_end = mode_q ? (i_q == OneIdx) : (i_q == LastIdx);

   // LFSR next value: seed load only honoured in idle, otherwise free-running Galois step.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
      if (seedLoad && (state_q == StIdle)) begin
         lfsr_d = (seed == 16'h0000) ? SEED : seed;
      end
   end

   // Next-state and datapath updates for the swap sequencer.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      pass_d  = pass_q;
      mode_d  = mode_q;
      reg_i_d = reg_i_q;
      reg_j_d = reg_j_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               mode_d = mode;
               pass_d = '0;
               if (mode) begin
                  i_d     = LastIdx;
                  state_d = (DEPTH == 1) ? StDone : StDraw;
               end else begin
                  i_d     = '0;
                  j_d     = OffsetIdx;
                  state_d = StRdI;
               end
            end
         end
         StDraw: begin
            // Rejection sampling: out-of-range candidates simply retry next cycle.
            if (cand <= i_q) begin
               j_d     = cand;
               state_d = StRdI;
            end
         end
         StRdI:  state_d = StRdJ;
         StRdJ: begin
            reg_i_d = memData;
            state_d = StCapJ;
         end
         StCapJ: begin
            reg_j_d = memData;
            state_d = StWrJ;
         end
         StWrJ:  state_d = StWrI;
         StWrI:  state_d = StNext;
         StNext: begin
            if (!pass_end) begin
               if (mode_q) begin
                  i_d     = i_q - OneIdx;
                  state_d = StDraw;
               end else begin
                  i_d     = i_q + OneIdx;
                  j_d     = j_wrap;
                  state_d = StRdI;
               end
            end else if (pass_q != LastPass) begin
               pass_d = pass_q + OnePass;
               if (mode_q) begin
                  i_d     = LastIdx;
                  state_d = StDraw;
               end else begin
                  i_d     = '0;
                  j_d     = OffsetIdx;
                  state_d = StRdI;
               end
            end else begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // RAM-side outputs decoded from registered state and index/data registers only.
   always_comb begin
      nextA   = '0;
      newData = '0;
      wren    = 1'b0;
      unique case (state_q)
         StRdI:  nextA = i_q;
         StRdJ:  nextA = j_q;
         StCapJ: nextA = j_q;
         StWrJ: begin
            nextA   = j_q;
            newData = reg_i_q;
            wren    = 1'b1;
         end
         StWrI: begin
            nextA   = i_q;
            newData = reg_j_q;
            wren    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy   = (state_q != StIdle);
   assign finish = (state_q == StDone);

   // State and datapath registers; reset aborts any swap in flight.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         pass_q  <= '0;
         mode_q  <= 1'b0;
         reg_i_q <= '0;
         reg_j_q <= '0;
         lfsr_q  <= SEED;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         pass_q  <= pass_d;
         mode_q  <= mode_d;
         reg_i_q <= reg_i_d;
         reg_j_q <= reg_j_d;
         lfsr_q  <= lfsr_d;
      end
   end

endmodule

// File: tb/tb_shuffler_param.sv
// Bench for shuffler_param: three instances (stride DEPTH=8, random DEPTH=52,
// stride DEPTH=8 with two passes), each with its own synchronous RAM model.
module tb_shuffler_param;

   logic        clock = 1'b0;
   logic        resetN;
   logic        mode;
   logic        seedLoad;
   logic [15:0] seed;
   logic        start_a, start_b, start_c;
   logic        pre_a, pre_b, pre_c;

   logic [3:0] md_a, nd_a;
   logic [2:0] na_a;
   logic       wr_a, busy_a, fin_a;
   logic [3:0] mem_a [8];

   logic [5:0] md_b, nd_b, na_b;
   logic       wr_b, busy_b, fin_b;
   logic [5:0] mem_b [52];

   logic [3:0] md_c, nd_c;
   logic [2:0] na_c;
   logic       wr_c, busy_c, fin_c;
   logic [3:0] mem_c [8];

   logic [5:0] ref_b  [52];
   logic [5:0] save_b [52];
   int         ref_draws;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   shuffler_param #(
      .DATA_W(4), .DEPTH(8), .ADDR_W(3), .STRIDE(3), .OFFSET(4), .PASSES(1), .SEED(16'hACE1)
   ) u_a (
      .clock(clock), .resetN(resetN), .start(start_a), .mode(mode), .seed(seed),
      .seedLoad(seedLoad), .memData(md_a), .nextA(na_a), .newData(nd_a), .wren(wr_a),
      .busy(busy_a), .finish(fin_a)
   );

   shuffler_param #(
      .DATA_W(6), .DEPTH(52), .ADDR_W(6), .STRIDE(3), .OFFSET(36), .PASSES(1), .SEED(16'hACE1)
   ) u_b (
      .clock(clock), .resetN(resetN), .start(start_b), .mode(mode), .seed(seed),
      .seedLoad(seedLoad), .memData(md_b), .nextA(na_b), .newData(nd_b), .wren(wr_b),
      .busy(busy_b), .finish(fin_b)
   );

   shuffler_param #(
      .DATA_W(4), .DEPTH(8), .ADDR_W(3), .STRIDE(3), .OFFSET(4), .PASSES(2), .SEED(16'hACE1)
   ) u_c (
      .clock(clock), .resetN(resetN), .start(start_c), .mode(mode), .seed(seed),
      .seedLoad(seedLoad), .memData(md_c), .nextA(na_c), .newData(nd_c), .wren(wr_c),
      .busy(busy_c), .finish(fin_c)
   );

   // Synchronous RAM models with a preload strobe writing mem[k]=k.
   always @(posedge clock) begin
      if (pre_a) for (int k = 0; k < 8; k++) mem_a[k] <= 4'(k);
      else if (wr_a) mem_a[na_a] <= nd_a;
      md_a <= mem_a[na_a];
   end

   always @(posedge clock) begin
      if (pre_b) for (int k = 0; k < 52; k++) mem_b[k] <= 6'(k);
      else if (wr_b) mem_b[na_b] <= nd_b;
      md_b <= mem_b[na_b];
   end

   always @(posedge clock) begin
      if (pre_c) for (int k = 0; k < 8; k++) mem_c[k] <= 4'(k);
      else if (wr_c) mem_c[na_c] <= nd_c;
      md_c <= mem_c[na_c];
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [31:0] pack_a();
      logic [31:0] r;
      for (int k = 0; k < 8; k++) r[4*k +: 4] = mem_a[k];
      return r;
   endfunction

   function automatic logic [31:0] pack_c();
      logic [31:0] r;
      for (int k = 0; k < 8; k++) r[4*k +: 4] = mem_c[k];
      return r;
   endfunction

   // Stride reference: swap s pairs slot s mod 8 with (4 + 3*(s mod 8)) mod 8.
   function automatic logic [31:0] stride_model(input int nsw);
      int          img [8];
      int          t, i, j;
      logic [31:0] r;
      for (int k = 0; k < 8; k++) img[k] = k;
      for (int s = 0; s < nsw; s++) begin
         i      = s % 8;
         j      = (4 + 3 * i) % 8;
         t      = img[i];
         img[i] = img[j];
         img[j] = t;
      end
      for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'(img[k]);
      return r;
   endfunction

   // Fisher-Yates reference: the first draw sees one LFSR step past the loaded seed,
   // every draw attempt costs one step and every swap six more.
   task automatic rand_model(input logic [15:0] sd);
      logic [15:0] l;
      int          m, c;
      logic [5:0]  t;
      l         = lstep(sd);
      ref_draws = 0;
      for (int k = 0; k < 52; k++) ref_b[k] = 6'(k);
      for (int i = 51; i >= 1; i--) begin
         m = 0;
         while (m < i) m = m * 2 + 1;
         do begin
            c = int'(l[5:0]) & m;
            l = lstep(l);
            ref_draws++;
         end while (c > i);
         t        = ref_b[i];
         ref_b[i] = ref_b[c];
         ref_b[c] = t;
         repeat (6) l = lstep(l);
      end
   endtask

   // Preload RAM (a pending seedLoad rides the same cycle), pulse start, then count
   // busy/finish/write cycles; start is re-pulsed on busy cycles rp1 and rp2.
   task automatic run(input int which, input bit md, input int rp1, input int rp2,
                      input bit chk, output int bcyc, output int fcnt, output int wcnt);
      int done_wr;
      bit prev_wr, b, f, w, rp;
      if (which == 0) pre_a = 1'b1;
      else if (which == 1) pre_b = 1'b1;
      else pre_c = 1'b1;
      tick();
      pre_a = 1'b0; pre_b = 1'b0; pre_c = 1'b0; seedLoad = 1'b0;
      mode = md;
      if (which == 0) start_a = 1'b1;
      else if (which == 1) start_b = 1'b1;
      else start_c = 1'b1;
      tick();
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      bcyc = 0; fcnt = 0; wcnt = 0; done_wr = 0; prev_wr = 1'b0; b = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         b = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
         f = (which == 0) ? fin_a  : (which == 1) ? fin_b  : fin_c;
         w = (which == 0) ? wr_a   : (which == 1) ? wr_b   : wr_c;
         if (prev_wr) done_wr++;
         if (chk && prev_wr && done_wr == 2) check("a_after_swap1", pack_a(), 32'h76503214);
         if (chk && prev_wr && done_wr == 4) check("a_after_swap2", pack_a(), 32'h16503274);
         if (!b) break;
         bcyc++;
         if (f) fcnt++;
         if (w) wcnt++;
         prev_wr = w;
         rp = (bcyc == rp1) || (bcyc == rp2);
         if (which == 0) start_a = rp;
         else if (which == 1) start_b = rp;
         else start_c = rp;
         tick();
      end
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      check($sformatf("run%0d_terminated", which), 32'(b), 32'd0);
   endtask

   initial begin
      int          bc, fc, wc, diff, cnt, perm_bad, n;
      logic [15:0] lm;
      resetN = 1'b0; mode = 1'b0; seedLoad = 1'b0; seed = 16'h0000;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      pre_a = 1'b0; pre_b = 1'b0; pre_c = 1'b0;
      repeat (3) tick();
      check("rst_nextA",   32'(na_a),   32'd0);
      check("rst_newData", 32'(nd_a),   32'd0);
      check("rst_wren",    32'(wr_a),   32'd0);
      check("rst_busy",    32'(busy_a), 32'd0);
      check("rst_finish",  32'(fin_a),  32'd0);
      check("rst_lfsr",    32'(u_a.lfsr_q), 32'hACE1);
      resetN = 1'b1;
      tick();

      // Stride walk, DEPTH=8: intermediate images, latency, write count, single finish.
      run(0, 1'b0, -1, -1, 1'b1, bc, fc, wc);
      check("a_busy_len",   32'(bc), 32'd49);
      check("a_finish_cnt", 32'(fc), 32'd1);
      check("a_wren_cnt",   32'(wc), 32'd16);
      check("a_final_model", pack_a(), stride_model(8));
      check("a_final_ident", pack_a(), 32'h76543210);

      // Start re-pulsed mid-run and in the DONE cycle must be ignored.
      run(0, 1'b0, 3, 20, 1'b0, bc, fc, wc);
      check("a_repulse_busy",  32'(bc), 32'd49);
      check("a_repulse_final", pack_a(), stride_model(8));
      run(0, 1'b0, 49, -1, 1'b0, bc, fc, wc);
      check("a_done_start_busy", 32'(bc), 32'd49);
      tick();
      check("a_done_start_idle", 32'(busy_a), 32'd0);

      // Zero seed loads the default seed.
      seed = 16'h0000; seedLoad = 1'b1;
      tick();
      seedLoad = 1'b0;
      check("lfsr_zero_seed", 32'(u_a.lfsr_q), 32'hACE1);

      // seedLoad while busy leaves the LFSR free-running.
      seed = 16'h5555; seedLoad = 1'b1;
      tick();
      seedLoad = 1'b0;
      lm = 16'h5555;
      check("lfsr_seed_load", 32'(u_a.lfsr_q), 32'(lm));
      mode = 1'b0; start_a = 1'b1;
      tick();
      start_a = 1'b0; lm = lstep(lm);
      tick();
      lm = lstep(lm);
      seed = 16'hFFFF; seedLoad = 1'b1;
      tick();
      seedLoad = 1'b0; lm = lstep(lm);
      check("lfsr_busy_ignore", 32'(u_a.lfsr_q), 32'(lm));
      n = 0;
      while (busy_a && n < 100) begin tick(); n++; end
      check("a_seedrun_done", 32'(busy_a), 32'd0);

      // Random mode, DEPTH=52: exact image, permutation, latency, repeatability.
      seed = 16'h1234; seedLoad = 1'b1;
      run(1, 1'b1, -1, -1, 1'b0, bc, fc, wc);
      rand_model(16'h1234);
      check("b_busy_len",   32'(bc), 32'(6 * 51 + ref_draws + 1));
      check("b_finish_cnt", 32'(fc), 32'd1);
      check("b_wren_cnt",   32'(wc), 32'd102);
      diff = 0;
      for (int k = 0; k < 52; k++) if (mem_b[k] !== ref_b[k]) diff++;
      check("b_model_img", 32'(diff), 32'd0);
      perm_bad = 0;
      for (int v = 0; v < 52; v++) begin
         cnt = 0;
         for (int k = 0; k < 52; k++) if (mem_b[k] === 6'(v)) cnt++;
         if (cnt != 1) perm_bad++;
      end
      check("b_permutation", 32'(perm_bad), 32'd0);
      for (int k = 0; k < 52; k++) save_b[k] = mem_b[k];

      seed = 16'h1234; seedLoad = 1'b1;
      run(1, 1'b1, -1, -1, 1'b0, bc, fc, wc);
      diff = 0;
      for (int k = 0; k < 52; k++) if (mem_b[k] !== save_b[k]) diff++;
      check("b_repeat_same", 32'(diff), 32'd0);

      seed = 16'h4321; seedLoad = 1'b1;
      run(1, 1'b1, -1, -1, 1'b0, bc, fc, wc);
      rand_model(16'h4321);
      diff = 0;
      for (int k = 0; k < 52; k++) if (mem_b[k] !== ref_b[k]) diff++;
      check("b_model_img2", 32'(diff), 32'd0);
      check("b_busy_len2",  32'(bc), 32'(6 * 51 + ref_draws + 1));
      diff = 0;
      for (int k = 0; k < 52; k++) if (mem_b[k] !== save_b[k]) diff++;
      check("b_seed_differs", 32'(diff != 0), 32'd1);

      // Two stride passes restore the original image.
      run(2, 1'b0, -1, -1, 1'b0, bc, fc, wc);
      check("c_busy_len",    32'(bc), 32'd97);
      check("c_finish_cnt",  32'(fc), 32'd1);
      check("c_final_model", pack_c(), stride_model(16));
      check("c_final_ident", pack_c(), 32'h76543210);

      // Reset during the first WR_J aborts at once; a fresh run is then correct.
      pre_a = 1'b1;
      tick();
      pre_a = 1'b0; mode = 1'b0; start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (!wr_a && n < 20) begin tick(); n++; end
      check("rst_mid_reached_wrj", 32'(wr_a), 32'd1);
      #2 resetN = 1'b0;
      #1;
      check("rst_mid_wren",   32'(wr_a),   32'd0);
      check("rst_mid_busy",   32'(busy_a), 32'd0);
      check("rst_mid_finish", 32'(fin_a),  32'd0);
      check("rst_mid_lfsr",   32'(u_a.lfsr_q), 32'hACE1);
      @(posedge clock);
      #1 resetN = 1'b1;
      tick();
      run(0, 1'b0, -1, -1, 1'b0, bc, fc, wc);
      check("rst_rerun_busy",  32'(bc), 32'd49);
      check("rst_rerun_final", pack_a(), stride_model(8));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
